// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern detector: host loads pattern/len/overlap/threshold,
// then a run scans qualified bits, pulses y per match and raises a sticky irq.
//
// state | meaning
// IDLE  | waiting for config load or start
// RUN   | scanning the qualified serial stream
// DONE  | threshold reached, waiting for irq_ack or stop
module seq_detect_ctrl #(
    parameter int PW = 8,
    parameter int LW = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [PW-1:0] cfg_pattern,
    input  logic [LW-1:0] cfg_len,
    input  logic          cfg_overlap,
    input  logic [CW-1:0] cfg_thresh,
    output logic          cfg_err,
    input  logic          start,
    input  logic          stop,
    input  logic          x,
    input  logic          x_valid,
    output logic          y,
    output logic [CW-1:0] match_count,
    output logic          irq,
    input  logic          irq_ack,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_next;
    logic          cfg_loaded;
    logic [PW-1:0] pat;
    logic [LW-1:0] len;
    logic          ovl;
    logic [CW-1:0] thresh;
    logic [PW-1:0] hist;
    logic [LW-1:0] fill;

    logic [PW-1:0] shifted;
    logic [PW-1:0] mask;
    logic          fill_ok;
    logic          sample;
    logic          hit;
    logic          thr_hit;
    logic          cfg_accept;
    logic          cfg_legal;
    logic          run_go;
    logic [CW-1:0] count_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mask       = '0;
        shifted    = {hist[PW-2:0], x};
        for (int i = 0; i < PW; i++) begin
            mask[i] = (i < int'(len));
        end
        fill_ok    = ({1'b0, fill} + (LW+1)'(1)) >= {1'b0, len};
        sample     = (state == RUN) && x_valid && !stop;
        hit        = sample && fill_ok && ((shifted & mask) == (pat & mask));
        count_inc  = (match_count == '1) ? match_count : match_count + CW'(1);
        thr_hit    = hit && (thresh != '0) && (count_inc == thresh);
        cfg_accept = cfg_valid && (state == IDLE);
        cfg_legal  = (cfg_len != '0) && (cfg_len <= LW'(PW));
        run_go     = (state == IDLE) && start && cfg_loaded;

        case (state)
            IDLE: if (run_go) state_next = RUN;
            RUN: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (thr_hit) begin
                    state_next = DONE;
                end
            end
            DONE: if (stop || irq_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_loaded  <= 1'b0;
            pat         <= '0;
            len         <= '0;
            ovl         <= 1'b0;
            thresh      <= '0;
            hist        <= '0;
            fill        <= '0;
            y           <= 1'b0;
            match_count <= '0;
            irq         <= 1'b0;
            cfg_err     <= 1'b0;
            cfg_ready   <= 1'b1;
            busy        <= 1'b0;
        end else begin
            y         <= 1'b0;
            cfg_err   <= 1'b0;
            cfg_ready <= (state_next == IDLE);
            busy      <= (state_next != IDLE);

            if (cfg_accept) begin
                if (cfg_legal) begin
                    pat         <= cfg_pattern;
                    len         <= cfg_len;
                    ovl         <= cfg_overlap;
                    thresh      <= cfg_thresh;
                    cfg_loaded  <= 1'b1;
                    match_count <= '0;
                end else begin
                    cfg_err <= 1'b1;
                end
            end

            if (run_go) begin
                hist        <= '0;
                fill        <= '0;
                match_count <= '0;
            end

            if (sample) begin
                hist <= shifted;
                // fill never exceeds len, so min(fill+1, len) reduces to fill_ok
                if (hit && !ovl) begin
                    fill <= '0;
                end else if (fill_ok) begin
                    fill <= len;
                end else begin
                    fill <= fill + LW'(1);
                end
            end

            if (hit) begin
                y           <= 1'b1;
                match_count <= count_inc;
            end

            if (thr_hit) begin
                irq <= 1'b1;
            end else if ((state == DONE) && (stop || irq_ack)) begin
                irq <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: inputs driven 1ns after the rising edge,
// outputs sampled 1ns after the following rising edge.
module tb_seq_detect_ctrl;

    localparam int PW = 8;
    localparam int LW = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [PW-1:0] cfg_pattern;
    logic [LW-1:0] cfg_len;
    logic          cfg_overlap;
    logic [CW-1:0] cfg_thresh;
    logic          cfg_err;
    logic          start;
    logic          stop;
    logic          x;
    logic          x_valid;
    logic          y;
    logic [CW-1:0] match_count;
    logic          irq;
    logic          irq_ack;
    logic          busy;

    int total = 0;
    int bad   = 0;

    seq_detect_ctrl #(.PW(PW), .LW(LW), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_thresh  (cfg_thresh),
        .cfg_err     (cfg_err),
        .start       (start),
        .stop        (stop),
        .x           (x),
        .x_valid     (x_valid),
        .y           (y),
        .match_count (match_count),
        .irq         (irq),
        .irq_ack     (irq_ack),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [PW-1:0] p, input logic [LW-1:0] l,
                        input logic o, input logic [CW-1:0] t);
        cfg_valid   = 1'b1;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        cfg_thresh  = t;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic b, input logic v);
        x       = b;
        x_valid = v;
        step();
        x_valid = 1'b0;
    endtask

    task automatic halt();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    logic [6:0] stream;
    logic [6:0] y_ovl;
    logic [6:0] y_novl;

    initial begin
        rst = 1'b1; cfg_valid = 0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0;
        cfg_thresh = '0; start = 0; stop = 0; x = 0; x_valid = 0; irq_ack = 0;
        stream = 7'b1010101;   // bit 6 is sent first
        y_ovl  = 7'b0010101;
        y_novl = 7'b0010001;
        step(); step();
        rst = 1'b0;
        step();

        check_val("rst_ready", cfg_ready, 1);
        check_val("rst_busy", busy, 0);
        check_val("rst_y", y, 0);
        check_val("rst_count", match_count, 0);
        check_val("rst_irq", irq, 0);
        check_val("rst_err", cfg_err, 0);
        go();
        step();
        check_val("nocfg_busy", busy, 0);

        // overlapping 101
        load(8'b101, 3, 1'b1, 0);
        check_val("ovl_cfg_err", cfg_err, 0);
        go();
        check_val("ovl_busy", busy, 1);
        check_val("ovl_ready", cfg_ready, 0);
        for (int i = 6; i >= 0; i--) begin
            send(stream[i], 1'b1);
            check_val($sformatf("ovl_y%0d", 7 - i), y, y_ovl[i]);
        end
        check_val("ovl_count", match_count, 3);
        halt();
        check_val("ovl_stop_busy", busy, 0);
        check_val("ovl_stop_count", match_count, 3);

        // non-overlapping 101
        load(8'b101, 3, 1'b0, 0);
        check_val("novl_load_count", match_count, 0);
        go();
        for (int i = 6; i >= 0; i--) begin
            send(stream[i], 1'b1);
            check_val($sformatf("novl_y%0d", 7 - i), y, y_novl[i]);
        end
        check_val("novl_count", match_count, 2);
        halt();

        // threshold with x_valid gaps
        load(8'b11, 2, 1'b1, 2);
        go();
        send(1'b1, 1'b1);
        check_val("thr_y1", y, 0);
        send(1'b0, 1'b0);
        send(1'b1, 1'b1);
        check_val("thr_y2", y, 1);
        check_val("thr_cnt2", match_count, 1);
        check_val("thr_irq2", irq, 0);
        send(1'b0, 1'b0);
        check_val("thr_gap_y", y, 0);
        send(1'b1, 1'b1);
        check_val("thr_y3", y, 1);
        check_val("thr_cnt3", match_count, 2);
        check_val("thr_irq3", irq, 1);
        check_val("thr_done_busy", busy, 1);
        check_val("thr_done_ready", cfg_ready, 0);
        send(1'b1, 1'b1);
        check_val("done_y_a", y, 0);
        send(1'b1, 1'b1);
        check_val("done_y_b", y, 0);
        check_val("done_count", match_count, 2);
        check_val("done_irq_held", irq, 1);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check_val("ack_ready", cfg_ready, 1);
        check_val("ack_irq", irq, 0);
        check_val("ack_busy", busy, 0);
        check_val("ack_count", match_count, 2);

        // illegal configs keep the 11/len2/thresh2 setup
        load(8'h00, 0, 1'b0, 0);
        check_val("err_len0", cfg_err, 1);
        step();
        check_val("err_len0_pulse", cfg_err, 0);
        load(8'h00, 9, 1'b0, 0);
        check_val("err_len9", cfg_err, 1);
        check_val("err_count_kept", match_count, 2);
        step();
        check_val("err_len9_pulse", cfg_err, 0);
        go();
        check_val("old_busy", busy, 1);
        send(1'b1, 1'b1);
        check_val("old_y1", y, 0);
        send(1'b1, 1'b1);
        check_val("old_y2", y, 1);
        check_val("old_count", match_count, 1);
        halt();

        // len 1 back-to-back matches, then stop against a matching sample
        load(8'b1, 1, 1'b1, 0);
        go();
        send(1'b1, 1'b1);
        check_val("b2b_y1", y, 1);
        send(1'b1, 1'b1);
        check_val("b2b_y2", y, 1);
        check_val("b2b_count", match_count, 2);
        x = 1'b1; x_valid = 1'b1; stop = 1'b1;
        step();
        x_valid = 1'b0; stop = 1'b0;
        check_val("stop_y", y, 0);
        check_val("stop_count", match_count, 2);
        check_val("stop_busy", busy, 0);
        check_val("stop_ready", cfg_ready, 1);

        // asynchronous reset mid-run
        go();
        send(1'b1, 1'b1);
        check_val("pre_rst_y", y, 1);
        rst = 1'b1;
        #1;
        check_val("arst_y", y, 0);
        check_val("arst_count", match_count, 0);
        check_val("arst_busy", busy, 0);
        check_val("arst_ready", cfg_ready, 1);
        check_val("arst_irq", irq, 0);
        #1;
        rst = 1'b0;
        step();
        go();
        step();
        check_val("arst_nocfg_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Programmable serial pattern-detection controller. It replaces fixed-pattern detectors such as the hard-wired "101" Mealy FSM with one configurable engine: a host loads a pattern, length, overlap mode and match threshold, then starts a run. The block scans a qualified serial bit stream, pulses `y` on each match, counts matches and raises a sticky interrupt when the threshold is reached. It sits between the serial input front-end and the host control/interrupt logic.

## Interface
- `PW`, 8: maximum pattern width in bits.
- `LW`, 4: width of the `cfg_len` field. Must satisfy 2^LW > PW.
- `CW`, 8: width of the match counter and threshold.
- `clk` in 1: the block's single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `cfg_valid` in 1: configuration offered.
- `cfg_ready` out 1: configuration accepted; high only in IDLE.
- `cfg_pattern` in PW: pattern. Bit 0 is the most recent (last-arriving) bit.
- `cfg_len` in LW: pattern length. Legal range is 1..PW.
- `cfg_overlap` in 1: 1 = overlapping matches allowed.
- `cfg_thresh` in CW: match count that triggers the interrupt. 0 disables the interrupt.
- `cfg_err` out 1: one-cycle pulse when an illegal config is rejected.
- `start` in 1: begin a run. Honoured only in IDLE with a valid config loaded.
- `stop` in 1: abort the run.
- `x` in 1: serial data bit.
- `x_valid` in 1: qualifies `x`.
- `y` out 1: registered one-cycle match pulse.
- `match_count` out CW: matches counted in the current run. Saturates at 2^CW-1.
- `irq` out 1: sticky threshold interrupt.
- `irq_ack` in 1: clears `irq`.
- `busy` out 1: high in RUN or DONE.

## Operation
- States:
  - IDLE (reset state).
  - RUN: scanning the stream.
  - DONE: threshold reached, waiting for acknowledge.
- Configuration transfer: `cfg_valid & cfg_ready`.
  - Legal `cfg_len`: latch pattern, length, overlap and threshold; set `cfg_loaded`; clear `match_count`.
  - Illegal `cfg_len` (0 or >PW): registers unchanged; `cfg_err`=1 for one cycle.
- IDLE -> RUN: on `start` with `cfg_loaded`=1. Clears the history register, fill counter and `match_count`. `start` without `cfg_loaded` is ignored.
- In RUN, for each cycle with `x_valid`=1:
  - `hist` <= {`hist`[PW-2:0], `x`}.
  - `fill` <= min(`fill`+1, `len`).
  - Match condition: `fill`+1 >= `len`, and the low `len` bits of {`hist`[PW-2:0], `x`} equal the low `len` bits of the pattern.
- On a match:
  - `y`=1 on the next cycle.
  - `match_count` increments, saturating.
  - If `cfg_overlap`=0, `fill` resets to 0, so the bits of this match cannot start another.
- Cycles with `x_valid`=0 leave `hist` and `fill` unchanged.
- RUN -> DONE: when the incremented count equals a nonzero `cfg_thresh`. On the same edge, `irq`=1.
- In DONE, the stream is ignored and `y` stays 0.
- DONE -> IDLE: on `irq_ack`, which also clears `irq`. `match_count` is retained until the next config load or `start`.
- `stop` in RUN or DONE returns to IDLE; in DONE it also clears `irq`.
- `stop` has priority over the same-cycle sample: that sample is discarded, with no match, count or `y`.
- `irq_ack` in IDLE or RUN has no effect.

## Timing
- Reset values: state=IDLE, `cfg_loaded`=0, `hist`=0, `fill`=0.
- Reset values of outputs: `cfg_ready`=1, `cfg_err`=0, `y`=0, `match_count`=0, `irq`=0, `busy`=0.
- Latency: the sample completing a match at edge N produces `y`=1 and the updated `match_count` during cycle N+1. `irq` rises in the same cycle as the threshold-reaching `y`.
- `cfg_ready`, `busy` and `irq` are registered, derived from state.
- `busy` rises the cycle after `start` is accepted.
- `y` is never high for two consecutive cycles unless matches occur on consecutive valid samples (e.g. pattern "1", len 1).
- Reset mid-run: immediate return to reset values, with no `y` pulse.

## Test plan
- Reset check: assert `rst` mid-RUN -> all outputs reach reset values before the next clock edge; `start` without a config is then ignored (`busy`=0).
- Overlap: pattern 3'b101, len 3, overlap 1, thresh 0; stream 1,0,1,0,1,0,1 -> `y` after samples 3, 5 and 7; `match_count`=3.
- Non-overlap: same pattern and stream with overlap 0 -> `y` after samples 3 and 7 only; `match_count`=2.
- Threshold and gaps: pattern 2'b11, len 2, thresh 2; stream 1,1,1 with `x_valid` gaps between samples -> `irq`=1 together with the second `y`; state DONE; further samples produce no `y`; `irq_ack` returns `cfg_ready`=1 and `irq`=0 with `match_count`=2 held.
- Config errors: `cfg_len`=0, then `cfg_len`=9 (PW=8) -> each gives a one-cycle `cfg_err` pulse; the previous config is retained; `start` then follows the old pattern.
- Stop priority: `stop` in the same cycle as a match-completing sample -> no `y`, `match_count` unchanged, state IDLE next cycle.
